// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences the shared datapath
// (PC, IR, ALU, memory, register bank) and counts retired instructions.
module controle_multiciclo (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  Opcode,
   input  logic        Mem_Pronto,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        IRWrite,
   output logic        ALUSrcA,
   output logic        RegWrite,
   output logic        RegDst,
   output logic [1:0]  ALUOp,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [3:0]  Estado,
   output logic        Opcode_Invalido,
   output logic [31:0] Instr_Concluidas
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      RTYPE_WB = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
   } state_t;

   state_t state;
   state_t state_next;
   logic   invalid_next;
   logic   retire;

   assign Estado = state;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic, invalid-opcode detection and retire strobe.
   always_comb begin
      state_next   = FETCH;
      invalid_next = 1'b0;
      retire       = 1'b0;
      case (state)
         FETCH:    state_next = Mem_Pronto ? DECODE : FETCH;
         DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               OP_J:         state_next = JUMP;
               OP_ADDI:      state_next = ADDI_EX;
               default: begin
                  state_next   = FETCH;
                  invalid_next = 1'b1;
               end
            endcase
         end
         // IR is frozen outside FETCH, so the live opcode is still the one decoded
         MEMADR: begin
            if (Opcode == OP_LW) begin
               state_next = MEMREAD;
            end else if (Opcode == OP_SW) begin
               state_next = MEMWRITE;
            end else begin
               state_next = FETCH;
            end
         end
         MEMREAD:  state_next = Mem_Pronto ? MEMWB : MEMREAD;
         MEMWRITE: begin
            if (Mem_Pronto) begin
               state_next = FETCH;
               retire     = 1'b1;
            end else begin
               state_next = MEMWRITE;
            end
         end
         EXECUTE:  state_next = RTYPE_WB;
         ADDI_EX:  state_next = ADDI_WB;
         MEMWB, RTYPE_WB, ADDI_WB, BRANCH, JUMP: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         default:  state_next = FETCH;
      endcase
   end

   // Moore output decode, forced low while reset is asserted.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      if (!reset) begin
         case (state)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = Mem_Pronto;
               PCWrite = Mem_Pronto;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEMREAD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            MEMWRITE: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            EXECUTE: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            RTYPE_WB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            ADDI_EX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            ADDI_WB:  RegWrite = 1'b1;
            default:  ;
         endcase
      end
   end

   // Invalid-opcode pulse and retired-instruction counter (wraps naturally).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Opcode_Invalido  <= 1'b0;
         Instr_Concluidas <= 32'd0;
      end else begin
         Opcode_Invalido <= invalid_next;
         if (retire) begin
            Instr_Concluidas <= Instr_Concluidas + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: hand-computed state/control vectors.
module tb_controle_multiciclo;

   logic        clk;
   logic        reset;
   logic [5:0]  Opcode;
   logic        Mem_Pronto;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic        IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0]  ALUOp, ALUSrcB, PCSource;
   logic [3:0]  Estado;
   logic        Opcode_Invalido;
   logic [31:0] Instr_Concluidas;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_cnt;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
   //  RegWrite,RegDst,ALUOp[1:0],ALUSrcB[1:0],PCSource[1:0]}
   logic [15:0] ctl;
   assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

   localparam logic [15:0] C_FETCH_WAIT = 16'h1004;
   localparam logic [15:0] C_FETCH_RDY  = 16'h9204;
   localparam logic [15:0] C_DECODE     = 16'h000C;
   localparam logic [15:0] C_MEMADR     = 16'h0108;
   localparam logic [15:0] C_MEMREAD    = 16'h3000;
   localparam logic [15:0] C_MEMWB      = 16'h0480;
   localparam logic [15:0] C_MEMWRITE   = 16'h2800;
   localparam logic [15:0] C_EXECUTE    = 16'h0120;
   localparam logic [15:0] C_RTYPE_WB   = 16'h00C0;
   localparam logic [15:0] C_BRANCH     = 16'h4111;
   localparam logic [15:0] C_JUMP       = 16'h8002;
   localparam logic [15:0] C_ADDI_EX    = 16'h0108;
   localparam logic [15:0] C_ADDI_WB    = 16'h0080;

   controle_multiciclo dut (
      .clk              (clk),
      .reset            (reset),
      .Opcode           (Opcode),
      .Mem_Pronto       (Mem_Pronto),
      .PCWrite          (PCWrite),
      .PCWriteCond      (PCWriteCond),
      .IorD             (IorD),
      .MemRead          (MemRead),
      .MemWrite         (MemWrite),
      .MemtoReg         (MemtoReg),
      .IRWrite          (IRWrite),
      .ALUSrcA          (ALUSrcA),
      .RegWrite         (RegWrite),
      .RegDst           (RegDst),
      .ALUOp            (ALUOp),
      .ALUSrcB          (ALUSrcB),
      .PCSource         (PCSource),
      .Estado           (Estado),
      .Opcode_Invalido  (Opcode_Invalido),
      .Instr_Concluidas (Instr_Concluidas)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected $finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply Mem_Pronto, check the current state's outputs, then advance one clock.
   task automatic cyc(input logic [3:0] st, input logic [15:0] c, input logic pronto);
      Mem_Pronto = pronto;
      #1;
      chk($sformatf("estado@%0t", $time), {28'd0, Estado}, {28'd0, st});
      chk($sformatf("ctl_s%0d@%0t", st, $time), {16'd0, ctl}, {16'd0, c});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      Opcode     = 6'b000000;
      Mem_Pronto = 1'b1;
      exp_cnt    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl",     {16'd0, ctl}, 32'd0);
      chk("rst_estado",  {28'd0, Estado}, 32'd0);
      chk("rst_cnt",     Instr_Concluidas, 32'd0);
      chk("rst_inv",     {31'd0, Opcode_Invalido}, 32'd0);
      reset = 1'b0;

      // R-type, memory always ready: 0,1,6,7,0
      Opcode = 6'b000000;
      cyc(4'd0, C_FETCH_RDY, 1'b1);
      cyc(4'd1, C_DECODE,    1'b1);
      cyc(4'd6, C_EXECUTE,   1'b1);
      cyc(4'd7, C_RTYPE_WB,  1'b1);
      exp_cnt = 32'd1;
      chk("rtype_cnt", Instr_Concluidas, exp_cnt);
      chk("rtype_back", {28'd0, Estado}, 32'd0);

      // LW with two wait cycles in MEMREAD: 0,1,2,3,3,3,4,0
      Opcode = 6'b100011;
      cyc(4'd0, C_FETCH_RDY, 1'b1);
      cyc(4'd1, C_DECODE,    1'b1);
      cyc(4'd2, C_MEMADR,    1'b1);
      cyc(4'd3, C_MEMREAD,   1'b0);
      cyc(4'd3, C_MEMREAD,   1'b0);
      cyc(4'd3, C_MEMREAD,   1'b1);
      cyc(4'd4, C_MEMWB,     1'b1);
      exp_cnt = 32'd2;
      chk("lw_cnt", Instr_Concluidas, exp_cnt);

      // SW with three FETCH wait cycles; no IRWrite/PCWrite until ready
      Opcode = 6'b101011;
      cyc(4'd0, C_FETCH_WAIT, 1'b0);
      cyc(4'd0, C_FETCH_WAIT, 1'b0);
      cyc(4'd0, C_FETCH_WAIT, 1'b0);
      cyc(4'd0, C_FETCH_RDY,  1'b1);
      cyc(4'd1, C_DECODE,     1'b1);
      cyc(4'd2, C_MEMADR,     1'b1);
      cyc(4'd5, C_MEMWRITE,   1'b1);
      exp_cnt = 32'd3;
      chk("sw_cnt", Instr_Concluidas, exp_cnt);

      // Unsupported opcode: 0,1,0 with a one-cycle invalid pulse, no retire
      Opcode = 6'b111111;
      cyc(4'd0, C_FETCH_RDY, 1'b1);
      chk("inv_decode", {31'd0, Opcode_Invalido}, 32'd0);
      cyc(4'd1, C_DECODE,    1'b1);
      chk("inv_pulse", {31'd0, Opcode_Invalido}, 32'd1);
      chk("inv_cnt",   Instr_Concluidas, exp_cnt);
      cyc(4'd0, C_FETCH_WAIT, 1'b0);
      chk("inv_clear", {31'd0, Opcode_Invalido}, 32'd0);

      // BEQ, J, ADDI back to back: 10 cycles, three retirements
      Opcode = 6'b000100;
      cyc(4'd0,  C_FETCH_RDY, 1'b1);
      cyc(4'd1,  C_DECODE,    1'b1);
      cyc(4'd8,  C_BRANCH,    1'b1);
      Opcode = 6'b000010;
      cyc(4'd0,  C_FETCH_RDY, 1'b1);
      cyc(4'd1,  C_DECODE,    1'b1);
      cyc(4'd9,  C_JUMP,      1'b1);
      Opcode = 6'b001000;
      cyc(4'd0,  C_FETCH_RDY, 1'b1);
      cyc(4'd1,  C_DECODE,    1'b1);
      cyc(4'd10, C_ADDI_EX,   1'b1);
      cyc(4'd11, C_ADDI_WB,   1'b1);
      exp_cnt = 32'd6;
      chk("seq_cnt", Instr_Concluidas, exp_cnt);

      // Reset in the middle of a stalled store
      Opcode = 6'b101011;
      cyc(4'd0, C_FETCH_RDY, 1'b1);
      cyc(4'd1, C_DECODE,    1'b1);
      cyc(4'd2, C_MEMADR,    1'b1);
      cyc(4'd5, C_MEMWRITE,  1'b0);
      chk("sw_stall_estado", {28'd0, Estado}, 32'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_ctl",    {16'd0, ctl}, 32'd0);
      chk("abort_estado", {28'd0, Estado}, 32'd0);
      chk("abort_cnt",    Instr_Concluidas, 32'd0);
      @(posedge clk);
      #1;
      chk("abort_ctl_edge", {16'd0, ctl}, 32'd0);
      reset = 1'b0;

      // Counter wrap: preload all ones, retire one R-type
      force dut.Instr_Concluidas = 32'hFFFF_FFFF;
      Opcode = 6'b000000;
      cyc(4'd0, C_FETCH_RDY, 1'b1);
      cyc(4'd1, C_DECODE,    1'b1);
      cyc(4'd6, C_EXECUTE,   1'b1);
      release dut.Instr_Concluidas;
      cyc(4'd7, C_RTYPE_WB,  1'b1);
      exp_cnt = 32'd0;
      chk("wrap_cnt",    Instr_Concluidas, exp_cnt);
      chk("wrap_estado", {28'd0, Estado}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Moore-style multi-cycle MIPS control unit that sequences the shared datapath: PC, instruction register, ALU, memory and the 32x32 register file.
- Decodes the opcode latched in the instruction register.
- Drives every datapath write-enable and mux select, including RegWrite into the register bank.
- Supports a memory-ready handshake and counts retired instructions.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  input  1  clock; all state changes on posedge
- reset  input  1  asynchronous, active-high; forces FETCH, clears counter and flags
- Opcode  input  6  instruction[31:26] from instruction register
- Mem_Pronto  input  1  memory ready; completes the current memory access
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- ALUOp, ALUSrcB, PCSource  output  2 each  datapath selects
- Estado  output  4  current state encoding, for debug
- Opcode_Invalido  output  1  registered one-cycle pulse on unsupported opcode
- Instr_Concluidas  output  32  retired-instruction counter

Behaviour:
- Reset and output gating:
  - reset=1 (asynchronous): state=FETCH (0), Instr_Concluidas=0, Opcode_Invalido=0.
  - Every control output is 0 while reset=1; outputs are gated by ~reset.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 are illegal and go to FETCH on the next edge.
- Outputs are decoded from the state; any output not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite=1 and PCWrite=1 only in the cycle where Mem_Pronto=1.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWRITE: MemWrite=1, IorD=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - RTYPE_WB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- Transitions:
  - FETCH->DECODE when Mem_Pronto=1; otherwise hold in FETCH.
  - DECODE dispatch by Opcode: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, J->JUMP, ADDI->ADDI_EX.
  - DECODE with any other opcode: ->FETCH, and Opcode_Invalido=1 for exactly the next cycle.
  - MEMADR->MEMREAD if LW, ->MEMWRITE if SW. Opcode is sampled live; the IR is stable because IRWrite=0.
  - MEMREAD->MEMWB when Mem_Pronto=1; otherwise hold.
  - MEMWRITE->FETCH when Mem_Pronto=1; otherwise hold. MemWrite stays asserted while waiting.
  - EXECUTE->RTYPE_WB, ADDI_EX->ADDI_WB.
  - MEMWB, RTYPE_WB, ADDI_WB, BRANCH and JUMP each go to FETCH.
- Latency with Mem_Pronto tied to 1: R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4 cycles. Each wait cycle adds one.
- Instr_Concluidas:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, RTYPE_WB, ADDI_WB, BRANCH or JUMP.
  - Does not increment on an invalid-opcode return or an illegal-state recovery.
  - Wraps from 0xFFFFFFFF to 0.
- RegWrite is asserted for exactly one cycle per writing instruction.
- Reset asserted mid-instruction (e.g. in MEMWRITE with Mem_Pronto=0) aborts immediately. No write-enable may be seen after the reset edge.

Test Plan:
- Reset, then hold Mem_Pronto=1 with Opcode=000000 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. Instr_Concluidas=1 after 4 cycles.
- Opcode=100011, Mem_Pronto low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 throughout state 3. MemtoReg=1 in state 4. Total 7 cycles.
- Opcode=101011, Mem_Pronto=0 for 3 FETCH cycles -> IRWrite=0 and PCWrite=0 during the waits. Both assert only in the ready cycle. MemWrite=1 in state 5. RegWrite is never 1.
- Opcode=111111 -> states 0,1,0; Opcode_Invalido=1 for one cycle; Instr_Concluidas unchanged.
- Sequence BEQ, J, ADDI -> BEQ gives PCWriteCond=1 and PCSource=01 in state 8. J gives PCWrite=1 and PCSource=10 in state 9. ADDI passes states 10 and 11. Counter=3 after 10 cycles.
- Assert reset while in MEMWRITE, then preload the counter to 0xFFFFFFFF (force) and retire one R-type -> all outputs 0 during reset and state=0. Counter wraps to 0.
